// File: rtl/onehot_rr_mux.sv
// N-channel one-hot selector with a registered output stage and valid/ready handshakes.
// MODE 0 selects the channel given by an external one-hot sel; MODE 1 arbitrates round-robin.
module onehot_rr_mux #(
    parameter int N    = 4,
    parameter int W    = 5,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic [N-1:0]   sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [N-1:0]   out_grant,
    input  logic           out_ready,
    output logic           sel_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic          ld;
    logic          xfer;
    logic          sel_multi;
    logic          sel_onehot;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rr_gnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] rr_idx;
    logic [PW-1:0] ptr_nxt;
    logic [W-1:0]  gnt_data;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign sel_multi  = (sel & (sel - ONE)) != '0;
    assign sel_onehot = (sel != '0) && !sel_multi;

    // Round-robin search starting at ptr and wrapping at N-1.
    always_comb begin
        int           idx;
        logic         found;
        logic [N-1:0] hot;
        idx    = 0;
        found  = 1'b0;
        hot    = '0;
        rr_gnt = '0;
        rr_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            hot = ONE << idx;
            if (!found && ((in_valid & hot) != '0)) begin
                found  = 1'b1;
                rr_gnt = hot;
                rr_idx = PW'(idx);
            end
        end
    end

    assign gnt      = (MODE == 0) ? (sel_onehot ? (sel & in_valid) : '0) : rr_gnt;
    assign ld       = ~out_valid | out_ready;
    assign in_ready = gnt & {N{ld}};
    assign xfer     = |in_ready;
    assign ptr_nxt  = (rr_idx == PW'(N - 1)) ? '0 : rr_idx + 1'b1;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_data = gnt_data | in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (ld) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data  <= gnt_data;
                    out_grant <= gnt;
                end
            end
            sel_err <= (MODE == 0) ? sel_multi : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if ((MODE == 1) && xfer) begin
            ptr <= ptr_nxt;
        end
    end

endmodule
